// File: rtl/hs_rx_buffer_pkg.sv
// Shared definitions for the multi-channel handshake receive buffer:
// default parameters, channel-tag width helper and the stored entry type.
package hs_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_CH_WIDTH   = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;

    // Channel tag width: clog2 of the channel count, never less than one bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Stored entry for the default configuration.
    typedef struct packed {
        logic [DEF_CH_WIDTH-1:0]   ch;
        logic [DEF_DATA_WIDTH-1:0] data;
    } hs_entry_t;

endpackage

// File: rtl/hs_rx_buffer_rr_arbiter.sv
// Round-robin arbiter for hs_rx_buffer. Grants the first requester at or above
// the priority pointer (wrapping), and moves the pointer past the winner
// whenever the caller signals that the grant was actually consumed.
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] prio;
    logic             found;

    // Search upward from the priority pointer for the first active request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = int'(prio) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // Priority moves to the channel after the one just served; holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= '0;
        end else if (advance) begin
            if (grant_idx == IDX_W'(NUM_CH - 1)) prio <= '0;
            else                                 prio <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/hs_rx_buffer.sv
// Multi-channel valid/ready receive buffer. NUM_CH producers are arbitrated
// round-robin (one beat per cycle) into a DEPTH-entry circular buffer that
// stores each beat with its channel tag; the head is presented first-word-
// fall-through on the output port.
// Optional build macro HS_RX_STATS_EN adds drop_cnt, a saturating count of
// cycles in which a producer was waiting while the buffer was full.
module hs_rx_buffer
    import hs_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CH_WIDTH   = ch_width(NUM_CH),
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rx_en,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_WIDTH-1:0]          out_ch,
    output logic [ADDR_WIDTH:0]          count,
`ifdef HS_RX_STATS_EN
    output logic [15:0]                  drop_cnt,
`endif
    output logic                         full
);

    typedef struct packed {
        logic [CH_WIDTH-1:0]   ch;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [NUM_CH-1:0]     grant;
    logic [CH_WIDTH-1:0]   grant_idx;
    logic                  push;
    logic                  pop;
    entry_t                head;

    hs_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (push),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake decode: only the granted channel sees ready, and only with room.
    always_comb begin
        full      = (count == (ADDR_WIDTH+1)'(DEPTH));
        out_valid = (count != '0);
        in_ready  = (rx_en && !full) ? grant : '0;
        push      = |(in_valid & in_ready);
        pop       = out_valid & out_ready;
        head      = mem[rd_ptr];
        out_data  = out_valid ? head.data : '0;
        out_ch    = out_valid ? head.ch   : '0;
    end

    // Buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ch: grant_idx, data: in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef HS_RX_STATS_EN
    // Saturating count of cycles where a producer waits on a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (rx_en && full && (|in_valid) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hs_rx_buffer.sv
// Directed bench for hs_rx_buffer (NUM_CH=4, DEPTH=16, DATA_WIDTH=8).
// Stimulus pushes expected {ch,data} beats into a queue; a monitor pops and
// compares every time the DUT hands over its head entry.
module tb_hs_rx_buffer;

    logic        clk;
    logic        rst_n;
    logic        rx_en;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic [4:0]  count;
    logic        full;
`ifdef HS_RX_STATS_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    hs_rx_buffer #(
        .DATA_WIDTH (8),
        .NUM_CH     (4),
        .DEPTH      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_en     (rx_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .count     (count),
`ifdef HS_RX_STATS_EN
        .drop_cnt  (drop_cnt),
`endif
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got ch%0d 0x%0h expected nothing", out_ch, out_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("pop_ch", 32'(out_ch), 32'(e[9:8]));
                check("pop_data", 32'(out_data), 32'(e[7:0]));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input int ch, input int data);
        exp_q.push_back({2'(ch), 8'(data)});
    endtask

    task automatic set_data(input int ch, input int data);
        in_data[ch*8 +: 8] = 8'(data);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain;
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (count == 5'd0) done = 1'b1;
        end
        out_ready = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: count %0d expected 0", count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_en     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_out_data", 32'(out_data), 0);
        do_reset();

        // Idle after reset
        check("idle_out_valid", 32'(out_valid), 0);
        check("idle_count", 32'(count), 0);
        check("idle_in_ready", 32'(in_ready), 0);

        // Single channel: ch2 sends three beats back to back
        in_valid = 4'b0100;
        set_data(2, 8'h11);
        #1 check("ch2_ready", 32'(in_ready), 32'h4);
        expect_beat(2, 8'h11);
        tick();
        set_data(2, 8'h22);
        expect_beat(2, 8'h22);
        tick();
        set_data(2, 8'h33);
        expect_beat(2, 8'h33);
        tick();
        in_valid = '0;
        #1;
        check("ch2_count", 32'(count), 3);
        check("ch2_full", 32'(full), 0);
        check("ch2_head_ch", 32'(out_ch), 2);
        check("ch2_head_data", 32'(out_data), 32'h11);
        drain();

        // Round-robin: all channels hold valid for 8 cycles
        do_reset();
        for (int c = 0; c < 4; c++) set_data(c, 8'hA0 + c);
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check("rr_grant", 32'(in_ready), 32'(1 << (k % 4)));
            expect_beat(k % 4, 8'hA0 + (k % 4));
            tick();
        end
        in_valid = '0;
        #1 check("rr_count", 32'(count), 8);
        drain();

        // Full boundary: 16 beats from ch0 with output stalled
        in_valid = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            set_data(0, 8'h40 + k);
            expect_beat(0, 8'h40 + k);
            tick();
        end
        set_data(0, 8'h5F);
        #1;
        check("full_flag", 32'(full), 1);
        check("full_count", 32'(count), 16);
        check("full_ready", 32'(in_ready), 0);
        expect_beat(0, 8'h5F);
        tick();
        check("full_hold_count", 32'(count), 16);
        check("full_hold_ready", 32'(in_ready), 0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("after_pop_count", 32'(count), 15);
        check("after_pop_ready", 32'(in_ready), 1);
        tick();
        in_valid = '0;
        #1 check("refill_count", 32'(count), 16);
`ifdef HS_RX_STATS_EN
        check("drop_cnt_full", 32'(drop_cnt), 3);
`endif
        drain();

        // Simultaneous push/pop at count 5, crossing the pointer wrap
        in_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            set_data(1, 8'h60 + k);
            expect_beat(1, 8'h60 + k);
            tick();
        end
        #1 check("pp_start_count", 32'(count), 5);
        out_ready = 1'b1;
        for (int k = 5; k < 11; k++) begin
            set_data(1, 8'h60 + k);
            expect_beat(1, 8'h60 + k);
            tick();
            check("pp_count", 32'(count), 5);
        end
        in_valid = '0;
        out_ready = 1'b0;
        drain();

        // rx_en low blocks every channel
        rx_en = 1'b0;
        in_valid = 4'b1111;
        #1 check("rxen_ready", 32'(in_ready), 0);
        tick();
        check("rxen_count", 32'(count), 0);
        in_valid = '0;
        rx_en = 1'b1;

        // Async reset mid-stream at count 7; ch1 traffic leaves priority at ch2
        in_valid = 4'b0010;
        for (int k = 0; k < 7; k++) begin
            set_data(1, 8'h70 + k);
            expect_beat(1, 8'h70 + k);
            tick();
        end
        in_valid = '0;
        #1 check("pre_rst_count", 32'(count), 7);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_out_data", 32'(out_data), 0);
        check("arst_out_ch", 32'(out_ch), 0);
`ifdef HS_RX_STATS_EN
        check("arst_drop_cnt", 32'(drop_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) set_data(c, 8'hA0 + c);
        in_valid = 4'b1111;
        #1 check("arst_rr_restart", 32'(in_ready), 1);
        expect_beat(0, 8'hA0);
        tick();
        in_valid = '0;
        drain();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hs_rx_buffer.md
Name: hs_rx_buffer

Overview:
- Multi-channel successor to the single-channel valid/ready capture receiver.
- Accepts beats from NUM_CH valid/ready producers through a round-robin arbiter, at most one beat per cycle.
- Each beat is stored with its channel tag in a circular buffer of DEPTH entries and drained through a valid/ready output port.
- Sits between the traffic generators and downstream consumer/checker logic in the handshake lab.

Parameters:
- DATA_WIDTH, 8, width of each data beat.
- NUM_CH, 4, number of input channels; legal range 1..16.
- CH_WIDTH, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of the channel tag.
- DEPTH, 16, buffer entries; any value >= 2, power of two not required.
- ADDR_WIDTH, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_en  input  1  global accept enable; when 0, all in_ready are 0.
- in_valid  input  NUM_CH  per-channel beat valid.
- in_ready  output  NUM_CH  per-channel ready; at most one bit set.
- in_data  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts the head entry.
- out_data  output  DATA_WIDTH  head entry data; 0 when empty.
- out_ch  output  CH_WIDTH  head entry channel tag; 0 when empty.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- ifdef HS_RX_STATS_EN: drop_cnt  output  16  cycles with any in_valid high while full and rx_en high.

Behaviour:
- Reset (rst_n low, asynchronous) clears: wr_ptr, rd_ptr, count, arbiter priority pointer (to channel 0), drop_cnt. Outputs then read out_valid=0, in_ready=0, full=0, count=0, out_data=0, out_ch=0. Buffer memory is not reset.
- Arbiter is combinational over in_valid. It grants the first valid channel searching upward from the priority pointer, wrapping at NUM_CH-1 to 0.
- in_ready[i] = rx_en & ~full & grant[i]. in_ready may depend combinationally on in_valid. Producers must hold valid and data until ready.
- Push occurs when in_valid[g] & in_ready[g]: mem[wr_ptr] <= {g, in_data[g]}; wr_ptr advances.
- On push, the priority pointer moves to g+1, wrapping to 0. With no push it holds. This guarantees no channel starves.
- Pop occurs when out_valid & out_ready: rd_ptr advances.
- Pointers wrap from DEPTH-1 to 0, for non-power-of-two DEPTH as well.
- Output is first-word-fall-through: out_data and out_ch are read combinationally from mem[rd_ptr] and gated to 0 when empty.
- Push-to-out_valid latency is 1 cycle. There is no empty-buffer bypass.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, pop is allowed but push is not, because ready is already low; count becomes DEPTH-1 and in_ready may assert the next cycle.
- When empty, out_valid=0, so out_ready is ignored and count never underflows.
- rx_en falling mid-stream: no accepts from the next cycle on. Stored data keeps draining, and the priority pointer holds.
- NUM_CH=1: arbiter degenerates to in_ready = rx_en & ~full, and out_ch is held at 0.

Optional Feature:
- Macro HS_RX_STATS_EN.
- Defined: adds the drop_cnt port, a 16-bit saturating counter (sticks at 16'hFFFF) that increments on each cycle where rx_en & full & |in_valid. Cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package hs_pkg holds:
  - the function deriving the channel tag width, clog2 with a minimum of 1;
  - localparam defaults for DATA_WIDTH, NUM_CH, DEPTH;
  - a typedef for the stored entry struct {ch, data}.
- One sub-module: hs_rr_arbiter. Parameter NUM_CH; inputs req and advance; outputs one-hot grant and grant_idx. It owns the priority pointer and uses the same clk and rst_n.
- The buffer and pointers stay in hs_rx_buffer.

Test Plan:
- Reset then idle: after rst_n deassert, with all in_valid=0 and rx_en=1 -> out_valid=0, count=0, in_ready=0.
- Single channel: ch2 sends 0x11, 0x22, 0x33 back-to-back with out_ready=0 -> count reaches 3 and full=0. Then out_ready=1 pops in order 0x11, 0x22, 0x33, with out_ch=2 on each.
- Round-robin fairness: all 4 channels hold valid with data 0xA0+ch for 8 cycles -> grant order 0,1,2,3,0,1,2,3, and out_ch pops in that same order.
- Full boundary: DEPTH=16, push 16 beats with out_ready=0 -> full=1, in_ready=0, a 17th beat is held. Pop once -> that beat is accepted next cycle and count returns to 16.
- Simultaneous push/pop at count=5 -> count stays 5, and data order is preserved across the pointer wrap from 15 to 0.
- Async reset mid-stream: assert rst_n low between clock edges at count=7 -> outputs clear immediately and the arbiter restarts at ch0. With HS_RX_STATS_EN, 3 valid cycles while full first yield drop_cnt=3, then 0 after reset.
